fetch_queue: RTL

//  Instruction fetch queue between instruction RAM/PC-mux and the decode stage. Buffers {pc, pc+4, instr}.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/constants.sv | 10 +
 rtl/fetch_queue.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants for the instruction fetch queue.
//   fq_entry_t : one buffered fetch {instr, pc, pcplf}
//   NOP_INS    : encoding substituted for a killed instruction (addi x0,x0,0)
// Widths come from constants.sv; fallbacks keep this file standalone.
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

package fetch_pkg;

    typedef struct packed {
        logic [`INSTR_SIZE-1:0] instr;
        logic [`PC_SIZE-1:0]    pc;
        logic [`PC_SIZE-1:0]    pcplf;
    } fq_entry_t;

    localparam logic [`INSTR_SIZE-1:0] NOP_INS = `INSTR_SIZE'(32'h0000_0013);

endpackage

// File: rtl/constants.sv
// Global datapath widths shared by the fetch path.
//   INSTR_SIZE : instruction word width in bits
//   PC_SIZE    : program counter width in bits
// Guarded so that a project-wide definition takes precedence.
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between the instruction RAM / PC mux
// and the decode stage.
//
// Ports
//   clk, nrst                     clock, asynchronous active-low reset
//   in_valid/in_instr/in_pc/in_pcplf  fetched word from RAM
//   pc_en                         ready to accept; PC register and predictor advance on 1
//   chng2nop                      kill the word enqueued in the previous cycle
//   flush                         drop all entries and any same-cycle enqueue
//   out_valid/out_ready           handshake to decode
//   out_instr/out_pc/out_pcplf    head entry
//   count                         occupied entries
//
// Configuration macro
//   IFQ_BYPASS_EN  when defined, an empty queue forwards in_* straight to out_*.
//
// A generic FIFO is not reused because the kill needs an indexed write into
// the youngest resident entry.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                     DEPTH   = 4,
    parameter logic [`INSTR_SIZE-1:0] NOP_INS = fetch_pkg::NOP_INS
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         in_valid,
    input  logic [`INSTR_SIZE-1:0]       in_instr,
    input  logic [`PC_SIZE-1:0]          in_pc,
    input  logic [`PC_SIZE-1:0]          in_pcplf,
    output logic                         pc_en,
    input  logic                         chng2nop,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [`INSTR_SIZE-1:0]       out_instr,
    output logic [`PC_SIZE-1:0]          out_pc,
    output logic [`PC_SIZE-1:0]          out_pcplf,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fq_entry_t         mem [DEPTH];
    logic [PW-1:0]     rd_ptr_reg;
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     last_idx_reg;
    logic [CW-1:0]     count_reg;
    logic              last_valid_reg;

    logic              empty;
    logic              full;
    logic              bypass;
    logic              enq;
    logic              deq;
    logic              wr;
    logic              kill;
    fq_entry_t         head;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));

`ifdef IFQ_BYPASS_EN
    assign bypass = empty & in_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = ~empty | bypass;
    assign pc_en     = ~full | (out_valid & out_ready);

    // enq covers bypassed words too (they still arm last_valid);
    // wr is the subset that actually lands in storage.
    assign enq  = in_valid & pc_en & ~flush;
    assign deq  = ~empty & out_ready & ~flush;
    assign wr   = enq & ~(bypass & out_ready);

    // The word enqueued last cycle is the tail, so it is resident exactly
    // when storage is non-empty. A bypassed word never reaches storage,
    // leaving count at zero and the kill ignored.
    assign kill = chng2nop & last_valid_reg & ~empty & ~flush;

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

    always_comb begin
        out_instr = head.instr;
        out_pc    = head.pc;
        out_pcplf = head.pcplf;
        if (bypass) begin
            out_instr = in_instr;
            out_pc    = in_pc;
            out_pcplf = in_pcplf;
        end else if (kill && (last_idx_reg == rd_ptr_reg)) begin
            // Kill lands on the head this cycle: show the NOP now so a
            // same-cycle dequeue never leaks the killed word.
            out_instr = NOP_INS;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            last_idx_reg   <= '0;
            count_reg      <= '0;
            last_valid_reg <= 1'b0;
        end else if (flush) begin
            rd_ptr_reg     <= wr_ptr_reg;
            count_reg      <= '0;
            last_valid_reg <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (deq) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (wr && !deq) begin
                count_reg <= count_reg + CW'(1);
            end else if (!wr && deq) begin
                count_reg <= count_reg - CW'(1);
            end
            last_valid_reg <= enq;
            if (enq) begin
                last_idx_reg <= wr_ptr_reg;
            end
        end
    end

    // Entry storage is not reset; count alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr_reg] <= '{instr: in_instr, pc: in_pc, pcplf: in_pcplf};
        end
        if (kill) begin
            mem[last_idx_reg].instr <= NOP_INS;
        end
    end

endmodule
